data_sram_bridge: RTL and testbench
===================================

# data_sram_bridge

Memory-stage responder for the pipeline's data-memory control (memwrite/memtoreg issued by the controller). It converts each M-stage load or store into one transaction on an SRAM-like bus (req / addr_ok / data_ok), holds the pipeline with stallM until the transaction completes, and returns the raw read word. It sits between the M-stage datapath/controller outputs and the data bus, and feeds stallM to the hazard unit.

## Interface
- AW, 32, address width
- DW, 32, data width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- memwriteM  in  1  M-stage store request
- memtoregM  in  1  M-stage load request
- flushM  in  1  M-stage instruction is being killed this cycle
- addrM  in  AW  byte address (aluoutM)
- sizeM  in  2  0 byte, 1 half, 2 word
- writedataM  in  DW  store data, already lane-aligned
- readdataM  out  DW  captured load word, valid in DONE
- stallM  out  1  hold F/D/E/M stages
- data_req  out  1  bus request
- data_wr  out  1  1 store, 0 load
- data_size  out  2  copy of sizeM
- data_addr  out  AW  registered address
- data_wdata  out  DW  registered store data
- data_addr_ok  in  1  bus accepted request this cycle
- data_data_ok  in  1  read data returned / write committed this cycle
- data_rdata  in  DW  read data, valid with data_data_ok

## Operation
- memreqM = memwriteM | memtoregM.
- States: IDLE, REQ, WAIT, DONE, DISCARD.
- IDLE: if memreqM & !flushM -> latch addr/size/wdata/wr into bus registers, go REQ; stallM=1 combinationally this cycle. Otherwise stallM=0.
- REQ: data_req=1, stallM=1. addr_ok -> WAIT. flushM before addr_ok -> drop req, IDLE.
- WAIT: data_req=0, stallM=1. data_ok -> capture data_rdata into readdataM (loads only; stores leave it unchanged), go DONE. flushM -> DISCARD.
- DONE: stallM=0 for exactly one cycle; pipeline advances at this edge; go IDLE unconditionally (next M instruction is examined in IDLE).
- DISCARD: stallM=1; data_ok -> IDLE, no capture.
- data_ok in REQ is a protocol violation; ignored. addr_ok outside REQ ignored.
- Bus address/size/wdata/wr held stable from REQ entry until leaving WAIT/DISCARD.
- One outstanding transaction maximum.

## Timing
- Reset: state IDLE; data_req, data_wr, data_size, data_addr, data_wdata, readdataM = 0; stallM follows IDLE rule (0 when memreqM=0).
- Minimum stall: 3 cycles (IDLE detect, REQ with same-cycle addr_ok, WAIT with data_ok next cycle), release in DONE.
- Each extra addr_ok or data_ok wait cycle adds one stall cycle.
- readdataM stable from DONE until next load captures.
- rst in any state aborts: data_req falls next cycle; late data_ok after reset is ignored.
- flushM in IDLE with memreqM: no request issued, stallM=0. flushM in DONE: no effect.

## Structure
- Shared package: state encodings (S_IDLE..S_DISCARD), size codes (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2).
- Single module; state and bus registers built on the codebase's resettable flop style (flopr with enable). No sub-module required.

## Test plan
- Load addr 0x0000_0010, addr_ok same cycle as req, data_ok next cycle with 0xDEAD_BEEF -> stallM high 3 cycles, readdataM=0xDEAD_BEEF in DONE, data_wr=0.
- Store word 0x1234_5678 to 0x20, addr_ok delayed 2 cycles, data_ok delayed 3 -> data_req held 3 cycles with stable addr/wdata, stallM high 7 cycles, readdataM unchanged.
- Back-to-back load then store -> DONE one cycle stallM=0, then new REQ; two distinct transactions, no lost request.
- flushM during REQ before addr_ok -> data_req drops next cycle, IDLE, no data_ok expected, stallM=0.
- flushM during WAIT, data_ok 2 cycles later with 0xFFFF_FFFF -> stallM held, readdataM keeps old value, return to IDLE.
- rst asserted in WAIT -> all outputs 0 next cycle, subsequent stray data_ok ignored.

Source files
------------

// File: rtl/data_sram_bridge_pkg.sv
// Shared types for the M-stage data SRAM bridge.
// State encodings and memory access size codes.
package data_sram_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DISCARD
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/data_sram_bridge.sv
// M-stage load/store to SRAM-like bus bridge with pipeline stall.
// Ports: M-stage request/flush/addr/size/wdata in, readdataM/stallM out,
// data_* SRAM bus (req/wr/size/addr/wdata out, addr_ok/data_ok/rdata in).
import data_sram_bridge_pkg::*;

module data_sram_bridge #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memwriteM,
  input  logic          memtoregM,
  input  logic          flushM,
  input  logic [AW-1:0] addrM,
  input  logic [1:0]    sizeM,
  input  logic [DW-1:0] writedataM,
  output logic [DW-1:0] readdataM,
  output logic          stallM,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata
);

  state_t state;
  logic   memreq;
  logic   issue;

  assign memreq = memwriteM | memtoregM;
  assign issue  = memreq & ~flushM;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wdata <= '0;
      readdataM  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            state      <= S_REQ;
            data_req   <= 1'b1;
            data_wr    <= memwriteM;
            data_size  <= sizeM;
            data_addr  <= addrM;
            data_wdata <= writedataM;
          end
        end
        S_REQ: begin
          // Once accepted the bus owes a data_ok, so a flush in the
          // same cycle must still drain it.
          if (data_addr_ok) begin
            data_req <= 1'b0;
            state    <= flushM ? S_DISCARD : S_WAIT;
          end else if (flushM) begin
            data_req <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            if (flushM) begin
              state <= S_IDLE;
            end else begin
              state <= S_DONE;
              if (!data_wr) readdataM <= data_rdata;
            end
          end else if (flushM) begin
            state <= S_DISCARD;
          end
        end
        S_DONE: state <= S_IDLE;
        S_DISCARD: begin
          if (data_data_ok) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // IDLE stalls on the detect cycle itself; DONE releases for one cycle.
  always_comb begin
    stallM = 1'b1;
    case (state)
      S_IDLE:  stallM = issue;
      S_DONE:  stallM = 1'b0;
      default: stallM = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge.
// Acts as pipeline and bus slave; checks stall length and read data.
import data_sram_bridge_pkg::*;

module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        memwriteM, memtoregM, flushM;
  logic [31:0] addrM, writedataM, readdataM;
  logic [1:0]  sizeM;
  logic        stallM, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rd = 32'h0;

  data_sram_bridge dut (
    .clk(clk), .rst(rst),
    .memwriteM(memwriteM), .memtoregM(memtoregM), .flushM(flushM),
    .addrM(addrM), .sizeM(sizeM), .writedataM(writedataM),
    .readdataM(readdataM), .stallM(stallM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      memwriteM = 1'b0; memtoregM = 1'b0; flushM = 1'b0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      #1;
      chk("idle_stall", 32'(stallM), 32'd0);
      chk("idle_req", 32'(data_req), 32'd0);
    end
  endtask

  // One transaction; the slave answers addr_ok after ad extra request
  // cycles and data_ok after dd extra wait cycles.
  task automatic run_txn(input bit st, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] wd,
                         input logic [31:0] rd, input int ad,
                         input int dd, input string tag);
    int stall_n = 0;
    int req_n   = 0;
    int wait_n  = 0;
    bit acc = 0;
    bit fin = 0;
    bit unstable = 0;
    bit rd_moved = 0;
    for (int c = 0; c < 64 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) begin
        memwriteM = st; memtoregM = !st; flushM = 1'b0;
        addrM = a; sizeM = sz; writedataM = wd;
      end
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      data_rdata = $urandom;
      #1;
      if (stallM === 1'b0) begin
        fin = 1;
      end else begin
        stall_n++;
        if (readdataM !== exp_rd) rd_moved = 1;
        if (data_req === 1'b1) begin
          req_n++;
          if (data_addr !== a || data_wdata !== wd ||
              data_size !== sz || data_wr !== st) unstable = 1;
          if (req_n == ad + 1) begin
            data_addr_ok = 1'b1;
            acc = 1;
          end
        end else if (acc) begin
          wait_n++;
          if (data_addr !== a || data_wdata !== wd) unstable = 1;
          if (wait_n == dd + 1) begin
            data_data_ok = 1'b1;
            data_rdata = rd;
          end
        end
        @(posedge clk);
      end
    end
    if (!st) exp_rd = rd;
    chk({tag, "_finished"}, 32'(fin), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(3 + ad + dd));
    chk({tag, "_req_cycles"}, 32'(req_n), 32'(ad + 1));
    chk({tag, "_bus_stable"}, 32'(unstable), 32'd0);
    chk({tag, "_rdata_hold"}, 32'(rd_moved), 32'd0);
    chk({tag, "_readdata"}, readdataM, exp_rd);
    chk({tag, "_wr"}, 32'(data_wr), 32'(st));
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    memwriteM = 1'b0; memtoregM = 1'b0; flushM = 1'b0;
    addrM = '0; sizeM = '0; writedataM = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_stall", 32'(stallM), 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_rdata", readdataM, 32'd0);
    rst = 1'b0;
    go_idle(1);

    run_txn(1'b0, 32'h10, SZ_WORD, 32'h0, 32'hDEAD_BEEF, 0, 0, "load_min");
    go_idle(1);
    run_txn(1'b1, 32'h20, SZ_WORD, 32'h1234_5678, 32'h5555_AAAA, 2, 2,
            "store_slow");
    go_idle(1);
    run_txn(1'b0, 32'h30, SZ_HALF, 32'h0, 32'hCAFE_F00D, 1, 0, "b2b_ld");
    run_txn(1'b1, 32'h34, SZ_BYTE, 32'h0000_00A5, 32'h0, 0, 1, "b2b_st");
    go_idle(1);

    // Flush with request in IDLE: nothing issued.
    @(negedge clk);
    memtoregM = 1'b1; addrM = 32'h44; flushM = 1'b1; #1;
    chk("flush_idle_stall", 32'(stallM), 32'd0);
    go_idle(1);

    // Flush during REQ before addr_ok.
    @(negedge clk);
    memtoregM = 1'b1; addrM = 32'h40; sizeM = SZ_WORD; #1;
    chk("freq_detect", 32'(stallM), 32'd1);
    @(negedge clk); #1;
    chk("freq_req", 32'(data_req), 32'd1);
    flushM = 1'b1;
    @(negedge clk);
    memtoregM = 1'b0; flushM = 1'b0; #1;
    chk("freq_drop", 32'(data_req), 32'd0);
    chk("freq_stall", 32'(stallM), 32'd0);
    go_idle(2);

    // Flush during WAIT; late data must not land.
    @(negedge clk);
    memtoregM = 1'b1; addrM = 32'h50; #1;
    @(negedge clk); #1;
    chk("fwait_req", 32'(data_req), 32'd1);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; #1;
    chk("fwait_wait_req", 32'(data_req), 32'd0);
    chk("fwait_wait_stall", 32'(stallM), 32'd1);
    flushM = 1'b1;
    @(negedge clk);
    flushM = 1'b0; memtoregM = 1'b0; #1;
    chk("fwait_discard_stall", 32'(stallM), 32'd1);
    @(negedge clk); #1;
    chk("fwait_discard_stall2", 32'(stallM), 32'd1);
    data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    data_data_ok = 1'b0; #1;
    chk("fwait_release", 32'(stallM), 32'd0);
    chk("fwait_rdata_kept", readdataM, exp_rd);
    go_idle(1);

    for (int i = 0; i < 12; i++) begin
      r = $urandom;
      run_txn(1'($urandom_range(0, 1)), {r[31:2], 2'b00},
              2'($urandom_range(0, 2)), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), "rand");
      if ($urandom_range(0, 1) == 1) go_idle(1);
    end
    go_idle(1);

    // Reset while waiting for data; stray data_ok afterwards.
    @(negedge clk);
    memtoregM = 1'b1; addrM = 32'h60; writedataM = 32'h77; #1;
    @(negedge clk); #1;
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; #1;
    chk("rst_wait_stall", 32'(stallM), 32'd1);
    rst = 1'b1; memtoregM = 1'b0;
    @(negedge clk);
    rst = 1'b0; #1;
    exp_rd = 32'h0;
    chk("rstw_req", 32'(data_req), 32'd0);
    chk("rstw_addr", data_addr, 32'd0);
    chk("rstw_wdata", data_wdata, 32'd0);
    chk("rstw_rdata", readdataM, 32'd0);
    chk("rstw_stall", 32'(stallM), 32'd0);
    data_data_ok = 1'b1; data_rdata = 32'h1357_9BDF;
    @(negedge clk);
    data_data_ok = 1'b0; #1;
    chk("stray_rdata", readdataM, 32'd0);
    chk("stray_stall", 32'(stallM), 32'd0);
    chk("stray_req", 32'(data_req), 32'd0);

    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      run_txn(1'($urandom_range(0, 1)), {r[31:2], 2'b00}, SZ_WORD,
              $urandom, $urandom, $urandom_range(0, 2),
              $urandom_range(0, 2), "rand2");
    end
    go_idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
